// File: rtl/ivl_ovl_fire_collector.sv
// Counts rising fail / X-check / cover events from NUM_CHK OVL fire buses, latches the first failure, escalates IDLE->WARN->FATAL.
// Outputs are registered and appear one cycle after the qualifying edge; there is no backpressure, so every cycle is accepted.
module ivl_ovl_fire_collector #(
  parameter int NUM_CHK   = 4,
  parameter int CNT_W     = 16,
  parameter int TS_W      = 32,
  parameter int ERR_LIMIT = 3
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 enable,
  input  logic                 clr,
  input  logic [NUM_CHK*3-1:0] fire_vec,
  output logic [CNT_W-1:0]     fail_cnt,
  output logic [CNT_W-1:0]     xchk_cnt,
  output logic [CNT_W-1:0]     cover_cnt,
  output logic                 first_valid,
  output logic [4:0]           first_id,
  output logic [TS_W-1:0]      first_ts,
  output logic [1:0]           state,
  output logic                 irq
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_WARN  = 2'b01,
    ST_FATAL = 2'b10,
    ST_BAD   = 2'b11
  } state_t;

  localparam int PW = 6;
  localparam int SW = CNT_W + PW + 1;
  localparam int CW = ((CNT_W > 32) ? CNT_W : 32) + 1;

  logic [NUM_CHK*3-1:0] fire_q;
  logic [NUM_CHK*3-1:0] edges;
  logic [NUM_CHK-1:0]   fail_e;
  logic [NUM_CHK-1:0]   xchk_e;
  logic [NUM_CHK-1:0]   cov_e;
  logic                 qual;
  logic                 any_fail;
  logic [4:0]           low_id;
  logic [CNT_W-1:0]     fail_nxt;
  logic [CNT_W-1:0]     xchk_nxt;
  logic [CNT_W-1:0]     cover_nxt;
  logic [TS_W-1:0]      ts;
  state_t               state_r;
  state_t               state_nxt;
  logic                 irq_nxt;

  function automatic logic [PW-1:0] popcnt(input logic [NUM_CHK-1:0] v);
    logic [PW-1:0] n;
    n = '0;
    for (int i = 0; i < NUM_CHK; i++) begin
      n = n + PW'(v[i]);
    end
    return n;
  endfunction

  function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] a,
                                               input logic [PW-1:0] b);
    logic [SW-1:0] s;
    s = SW'(a) + SW'(b);
    if (s > SW'({CNT_W{1'b1}})) begin
      return {CNT_W{1'b1}};
    end
    return s[CNT_W-1:0];
  endfunction

  assign qual  = enable & ~clr;
  assign edges = fire_vec & ~fire_q;

  always_comb begin
    fail_e = '0;
    xchk_e = '0;
    cov_e  = '0;
    for (int i = 0; i < NUM_CHK; i++) begin
      fail_e[i] = edges[3*i]   & qual;
      xchk_e[i] = edges[3*i+1] & qual;
      cov_e[i]  = edges[3*i+2] & qual;
    end
  end

  // Scan from the top so the lowest failing index wins.
  always_comb begin
    low_id = '0;
    for (int i = NUM_CHK - 1; i >= 0; i--) begin
      if (fail_e[i]) begin
        low_id = 5'(i);
      end
    end
  end

  assign any_fail  = |fail_e;
  assign fail_nxt  = clr ? '0 : sat_add(fail_cnt,  popcnt(fail_e));
  assign xchk_nxt  = clr ? '0 : sat_add(xchk_cnt,  popcnt(xchk_e));
  assign cover_nxt = clr ? '0 : sat_add(cover_cnt, popcnt(cov_e));

  // fire_q keeps tracking the bus during reset so a fire held across reset release is not an edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      fire_q      <= fire_vec;
      fail_cnt    <= '0;
      xchk_cnt    <= '0;
      cover_cnt   <= '0;
      ts          <= '0;
      first_valid <= 1'b0;
      first_id    <= '0;
      first_ts    <= '0;
    end else begin
      fire_q    <= fire_vec;
      fail_cnt  <= fail_nxt;
      xchk_cnt  <= xchk_nxt;
      cover_cnt <= cover_nxt;
      ts        <= ts + 1'b1;
      if (clr) begin
        first_valid <= 1'b0;
        first_id    <= '0;
        first_ts    <= '0;
      end else if (any_fail && !first_valid) begin
        first_valid <= 1'b1;
        first_id    <= low_id;
        first_ts    <= ts;
      end
    end
  end

  always_comb begin
    state_nxt = state_r;
    if (clr) begin
      state_nxt = ST_IDLE;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (CW'(fail_nxt) >= CW'(ERR_LIMIT)) begin
            state_nxt = ST_FATAL;
          end else if (fail_nxt != '0) begin
            state_nxt = ST_WARN;
          end
        end
        ST_WARN: begin
          if (CW'(fail_nxt) >= CW'(ERR_LIMIT)) begin
            state_nxt = ST_FATAL;
          end
        end
        ST_FATAL: state_nxt = ST_FATAL;
        default:  state_nxt = ST_FATAL;
      endcase
    end
    irq_nxt = (state_nxt != state_r) &&
              ((state_nxt == ST_WARN) || (state_nxt == ST_FATAL));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= ST_IDLE;
      irq     <= 1'b0;
    end else begin
      state_r <= state_nxt;
      irq     <= irq_nxt;
    end
  end

  assign state = state_r;

endmodule
